// File: rtl/cpu_seq.sv
// Phase sequencer and program-counter controller: FT/DC/EX/WB strobes, fetch handshake, PC and retire count.
// Optional single-step start is enabled by defining SEQ_STEP_EN.
module cpu_seq #(
  parameter int FETCH_TO = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic        step,
  input  logic        imem_ack,
  input  logic        dec_jump,
  input  logic        cond,
  input  logic [7:0]  jmp_target,
  input  logic        dec_halt,
  input  logic        dec_wb,
  output logic        clk_ft,
  output logic        clk_dc,
  output logic        clk_ex,
  output logic        clk_wb,
  output logic        imem_req,
  output logic [7:0]  p_count,
  output logic        reg_we,
  output logic        halted,
  output logic        fault,
  output logic [15:0] icount
);

  typedef enum logic [2:0] {IDLE, FT, DC, EX, WB, HALT, FAULT} state_t;

  localparam logic [15:0] TO_LAST = (FETCH_TO > 0) ? 16'(FETCH_TO - 1) : 16'd0;

  state_t      state;
  state_t      state_nxt;
  logic [15:0] wait_cnt;
  logic        start;
  logic        timeout;

`ifdef SEQ_STEP_EN
  assign start = run | step;
`else
  logic step_unused;
  assign step_unused = step;
  assign start = run;
`endif

  // wait_cnt holds the number of completed FT cycles, so it equals TO_LAST during the last allowed one
  assign timeout = (FETCH_TO != 0) && (wait_cnt == TO_LAST);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = FT;
      FT: begin
        if (imem_ack)     state_nxt = DC;
        else if (timeout) state_nxt = FAULT;
      end
      DC:      state_nxt = EX;
      EX:      state_nxt = WB;
      WB: begin
        if (dec_halt)     state_nxt = HALT;
        else if (run)     state_nxt = FT;
        else              state_nxt = IDLE;
      end
      HALT:    state_nxt = HALT;
      FAULT:   state_nxt = FAULT;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      clk_ft   <= 1'b0;
      clk_dc   <= 1'b0;
      clk_ex   <= 1'b0;
      clk_wb   <= 1'b0;
      imem_req <= 1'b0;
      halted   <= 1'b0;
      fault    <= 1'b0;
      wait_cnt <= 16'd0;
      p_count  <= 8'd0;
      icount   <= 16'd0;
    end else begin
      state    <= state_nxt;
      clk_ft   <= (state_nxt == FT);
      clk_dc   <= (state_nxt == DC);
      clk_ex   <= (state_nxt == EX);
      clk_wb   <= (state_nxt == WB);
      imem_req <= (state_nxt == FT);
      halted   <= (state_nxt == HALT);
      fault    <= (state_nxt == FAULT);
      wait_cnt <= (state == FT && state_nxt == FT) ? wait_cnt + 16'd1 : 16'd0;
      if (state == WB) begin
        icount <= icount + 16'd1;
        // halt outranks jump: PC stays on the halt instruction
        if (!dec_halt) begin
          if (dec_jump && cond) p_count <= jmp_target;
          else                  p_count <= p_count + 8'd1;
        end
      end
    end
  end

  assign reg_we = clk_wb & dec_wb;

endmodule

// File: tb/tb_cpu_seq.sv
// Directed bench for cpu_seq: per-cycle vector table plus hand-written reset, timeout, halt and step sequences.
module tb_cpu_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        run = 1'b0, step = 1'b0, imem_ack = 1'b0;
  logic        dec_jump = 1'b0, cond = 1'b0, dec_halt = 1'b0, dec_wb = 1'b0;
  logic [7:0]  jmp_target = 8'd0;
  logic        clk_ft, clk_dc, clk_ex, clk_wb, imem_req, reg_we, halted, fault;
  logic [7:0]  p_count;
  logic [15:0] icount;

  int errors = 0;
  int checks = 0;

  cpu_seq #(.FETCH_TO(15)) dut (
    .clk(clk), .reset(reset), .run(run), .step(step), .imem_ack(imem_ack),
    .dec_jump(dec_jump), .cond(cond), .jmp_target(jmp_target),
    .dec_halt(dec_halt), .dec_wb(dec_wb),
    .clk_ft(clk_ft), .clk_dc(clk_dc), .clk_ex(clk_ex), .clk_wb(clk_wb),
    .imem_req(imem_req), .p_count(p_count), .reg_we(reg_we),
    .halted(halted), .fault(fault), .icount(icount)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t required below 200000", $time);
    $fatal(1);
  end

  typedef struct {
    logic       run, ack, jump, cnd;
    logic [7:0] tgt;
    logic       wb;
    logic [3:0] strb;
    logic [7:0] pc;
    logic [15:0] ic;
    logic       we;
  } vec_t;

  vec_t tbl[30];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  // {ft,dc,ex,wb,imem_req,halted,fault}
  function automatic logic [6:0] flags;
    return {clk_ft, clk_dc, clk_ex, clk_wb, imem_req, halted, fault};
  endfunction

  task automatic clear_inputs;
    run = 0; step = 0; imem_ack = 0; dec_jump = 0; cond = 0;
    dec_halt = 0; dec_wb = 0; jmp_target = 8'd0;
  endtask

  task automatic do_reset;
    clear_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("reset_flags", {25'd0, flags()}, 32'd0);
    chk("reset_pc", {24'd0, p_count}, 32'd0);
    chk("reset_icount", {16'd0, icount}, 32'd0);
  endtask

  initial begin
    // run ack jump cond tgt wb | {ft,dc,ex,wb} pc icount reg_we
    tbl[0]  = '{1,1,0,0,8'h00,0, 4'b1000, 8'h00, 16'd0, 0};
    tbl[1]  = '{1,1,0,0,8'h00,0, 4'b0100, 8'h00, 16'd0, 0};
    tbl[2]  = '{1,0,0,0,8'h00,0, 4'b0010, 8'h00, 16'd0, 0};
    tbl[3]  = '{1,0,0,0,8'h00,1, 4'b0001, 8'h00, 16'd0, 1};
    tbl[4]  = '{1,1,1,1,8'h40,0, 4'b1000, 8'h40, 16'd1, 0};
    tbl[5]  = '{1,1,0,0,8'h00,0, 4'b0100, 8'h40, 16'd1, 0};
    tbl[6]  = '{1,0,0,0,8'h00,0, 4'b0010, 8'h40, 16'd1, 0};
    tbl[7]  = '{1,0,1,0,8'h40,0, 4'b0001, 8'h40, 16'd1, 0};
    tbl[8]  = '{1,0,1,0,8'h40,0, 4'b1000, 8'h41, 16'd2, 0};
    tbl[9]  = '{1,0,0,0,8'h00,0, 4'b1000, 8'h41, 16'd2, 0};
    tbl[10] = '{1,0,0,0,8'h00,0, 4'b1000, 8'h41, 16'd2, 0};
    tbl[11] = '{1,0,0,0,8'h00,0, 4'b1000, 8'h41, 16'd2, 0};
    tbl[12] = '{1,1,0,0,8'h00,0, 4'b0100, 8'h41, 16'd2, 0};
    tbl[13] = '{1,1,0,0,8'h00,0, 4'b0010, 8'h41, 16'd2, 0};
    tbl[14] = '{1,1,0,0,8'h00,1, 4'b0001, 8'h41, 16'd2, 1};
    tbl[15] = '{0,0,0,0,8'h00,0, 4'b0000, 8'h42, 16'd3, 0};
    tbl[16] = '{1,1,0,0,8'h00,0, 4'b1000, 8'h42, 16'd3, 0};
    tbl[17] = '{0,1,0,0,8'h00,0, 4'b0100, 8'h42, 16'd3, 0};
    tbl[18] = '{0,0,0,0,8'h00,0, 4'b0010, 8'h42, 16'd3, 0};
    tbl[19] = '{0,0,0,0,8'h00,1, 4'b0001, 8'h42, 16'd3, 1};
    tbl[20] = '{0,0,0,0,8'h00,0, 4'b0000, 8'h43, 16'd4, 0};
    tbl[21] = '{1,1,0,0,8'h00,0, 4'b1000, 8'h43, 16'd4, 0};
    tbl[22] = '{1,1,0,0,8'h00,0, 4'b0100, 8'h43, 16'd4, 0};
    tbl[23] = '{1,0,0,0,8'h00,0, 4'b0010, 8'h43, 16'd4, 0};
    tbl[24] = '{1,0,0,0,8'h00,0, 4'b0001, 8'h43, 16'd4, 0};
    tbl[25] = '{1,1,1,1,8'hFF,0, 4'b1000, 8'hFF, 16'd5, 0};
    tbl[26] = '{1,1,0,0,8'h00,0, 4'b0100, 8'hFF, 16'd5, 0};
    tbl[27] = '{1,0,0,0,8'h00,0, 4'b0010, 8'hFF, 16'd5, 0};
    tbl[28] = '{1,0,0,0,8'h00,0, 4'b0001, 8'hFF, 16'd5, 0};
    tbl[29] = '{0,0,0,0,8'h00,0, 4'b0000, 8'h00, 16'd6, 0};

    // Table: jump taken/not taken, delayed ack, run dropped, PC wrap
    do_reset();
    for (int i = 0; i < 30; i++) begin
      run = tbl[i].run; imem_ack = tbl[i].ack; dec_jump = tbl[i].jump;
      cond = tbl[i].cnd; jmp_target = tbl[i].tgt; dec_wb = tbl[i].wb;
      tick();
      chk($sformatf("tbl%0d_flags", i), {25'd0, flags()},
          {25'd0, tbl[i].strb, tbl[i].strb[3], 2'b00});
      chk($sformatf("tbl%0d_pc", i), {24'd0, p_count}, {24'd0, tbl[i].pc});
      chk($sformatf("tbl%0d_icount", i), {16'd0, icount}, {16'd0, tbl[i].ic});
      chk($sformatf("tbl%0d_reg_we", i), {31'd0, reg_we}, {31'd0, tbl[i].we});
    end

    // Eight back-to-back instructions, then reset asserted during DC
    do_reset();
    run = 1; imem_ack = 1;
    for (int k = 1; k <= 33; k++) begin
      logic [3:0] exp_s;
      tick();
      case (k % 4)
        1: exp_s = 4'b1000;
        2: exp_s = 4'b0100;
        3: exp_s = 4'b0010;
        default: exp_s = 4'b0001;
      endcase
      chk($sformatf("seq%0d_strobes", k), {28'd0, clk_ft, clk_dc, clk_ex, clk_wb}, {28'd0, exp_s});
      chk($sformatf("seq%0d_pc", k), {24'd0, p_count}, 32'((k - 1) / 4));
    end
    chk("seq_icount8", {16'd0, icount}, 32'd8);
    tick();
    chk("seq_in_dc", {25'd0, flags()}, {25'd0, 7'b0100000});
    #2 reset = 1'b1;
    #1;
    chk("async_reset_flags", {24'd0, reg_we, flags()}, 32'd0);
    chk("async_reset_pc", {24'd0, p_count}, 32'd0);
    chk("async_reset_icount", {16'd0, icount}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Fetch timeout after 15 FT cycles; terminal until reset
    do_reset();
    run = 1;
    tick();
    for (int k = 2; k <= 15; k++) tick();
    chk("to_ft15_flags", {25'd0, flags()}, {25'd0, 7'b1000100});
    tick();
    chk("to_fault_flags", {25'd0, flags()}, {25'd0, 7'b0000001});
    run = 0; tick();
    run = 1; imem_ack = 1; tick(); tick();
    chk("to_fault_sticky", {25'd0, flags()}, {25'd0, 7'b0000001});
    chk("to_fault_pc", {24'd0, p_count}, 32'd0);

    // Ack in the 15th FT cycle wins over the timeout
    do_reset();
    run = 1;
    tick();
    for (int k = 2; k <= 15; k++) tick();
    imem_ack = 1;
    tick();
    chk("to_ack_wins", {25'd0, flags()}, {25'd0, 7'b0100000});

    // Halt together with a taken jump
    do_reset();
    run = 1; imem_ack = 1;
    tick(); tick(); tick();
    dec_halt = 1; dec_jump = 1; cond = 1; jmp_target = 8'h40; dec_wb = 1;
    tick();
    chk("halt_wb_reg_we", {31'd0, reg_we}, 32'd1);
    tick();
    chk("halt_flags", {25'd0, flags()}, {25'd0, 7'b0000010});
    chk("halt_pc", {24'd0, p_count}, 32'd0);
    chk("halt_icount", {16'd0, icount}, 32'd1);
    run = 0; tick();
    run = 1; tick(); tick();
    chk("halt_sticky", {25'd0, flags()}, {25'd0, 7'b0000010});
    chk("halt_icount_hold", {16'd0, icount}, 32'd1);

    // Two step pulses with run low
    do_reset();
    imem_ack = 1;
    for (int p = 0; p < 2; p++) begin
      step = 1; tick();
      step = 0;
      for (int k = 0; k < 5; k++) tick();
    end
`ifdef SEQ_STEP_EN
    chk("step_icount", {16'd0, icount}, 32'd2);
    chk("step_pc", {24'd0, p_count}, 32'd2);
`else
    chk("step_icount", {16'd0, icount}, 32'd0);
    chk("step_pc", {24'd0, p_count}, 32'd0);
`endif
    chk("step_idle", {25'd0, flags()}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
